// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bus: IF/ID inputs, reg_file read/writeback nets and the ID/EX register outputs.
// The stage uses the slave modport; the driving side (decode / testbench) uses master.
interface id_ex_if #(
  parameter int CTRL_W      = 8,
  parameter int STALL_CNT_W = 16
);
  logic                   in_valid;
  logic [31:0]            in_pc;
  logic [31:0]            in_imm;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [4:0]             in_rd;
  logic                   in_is_load;
  logic [CTRL_W-1:0]      in_ctrl;
  logic                   flush;

  logic [4:0]             A1;
  logic [4:0]             A2;
  logic [31:0]            RD1;
  logic [31:0]            RD2;
  logic [4:0]             wb_A3;
  logic [31:0]            wb_WD3;
  logic                   wb_WE3;

  logic                   stall_req;
  logic                   ex_valid;
  logic [31:0]            ex_pc;
  logic [31:0]            ex_imm;
  logic [4:0]             ex_rs1;
  logic [4:0]             ex_rs2;
  logic [4:0]             ex_rd;
  logic                   ex_is_load;
  logic [CTRL_W-1:0]      ex_ctrl;
  logic [31:0]            ex_op1;
  logic [31:0]            ex_op2;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_is_load, in_ctrl, flush,
    output RD1, RD2, wb_A3, wb_WD3, wb_WE3,
    input  A1, A2, stall_req,
    input  ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_ctrl,
    input  ex_op1, ex_op2, stall_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_rs1, in_rs2, in_rd, in_is_load, in_ctrl, flush,
    input  RD1, RD2, wb_A3, wb_WD3, wb_WE3,
    output A1, A2, stall_req,
    output ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_ctrl,
    output ex_op1, ex_op2, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and saturating stall counter.
// Define IDEX_WB_BYPASS_EN to forward the same-cycle writeback value around reg_file.
module id_ex_stage #(
  parameter int CTRL_W      = 8,
  parameter int STALL_CNT_W = 16
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);

  logic              hazard;
  logic [31:0]       op1_d;
  logic [31:0]       op2_d;
  logic [CTRL_W-1:0] ctrl_d;

  assign bus.A1 = bus.in_rs1;
  assign bus.A2 = bus.in_rs2;

  assign hazard = bus.in_valid & bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                  ((bus.ex_rd == bus.in_rs1) | (bus.ex_rd == bus.in_rs2));

  // A flush squashes the waiting instruction, so there is nothing to hold upstream.
  assign bus.stall_req = hazard & ~bus.flush;
  assign ctrl_d        = bus.in_ctrl;

  always_comb begin
    op1_d = bus.RD1;
    op2_d = bus.RD2;
`ifdef IDEX_WB_BYPASS_EN
    if (bus.wb_WE3 && bus.wb_A3 != 5'd0 && bus.wb_A3 == bus.in_rs1) op1_d = bus.wb_WD3;
    if (bus.wb_WE3 && bus.wb_A3 != 5'd0 && bus.wb_A3 == bus.in_rs2) op2_d = bus.wb_WD3;
`endif
    if (bus.in_rs1 == 5'd0) op1_d = 32'd0;
    if (bus.in_rs2 == 5'd0) op2_d = 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_pc      <= '0;
      bus.ex_imm     <= '0;
      bus.ex_rs1     <= '0;
      bus.ex_rs2     <= '0;
      bus.ex_rd      <= '0;
      bus.ex_is_load <= 1'b0;
      bus.ex_ctrl    <= '0;
      bus.ex_op1     <= '0;
      bus.ex_op2     <= '0;
    end else if (bus.flush || hazard) begin
      // Bubble: clearing ex_is_load guarantees the load-use stall lasts one cycle.
      bus.ex_valid   <= 1'b0;
      bus.ex_pc      <= '0;
      bus.ex_imm     <= '0;
      bus.ex_rs1     <= '0;
      bus.ex_rs2     <= '0;
      bus.ex_rd      <= '0;
      bus.ex_is_load <= 1'b0;
      bus.ex_ctrl    <= '0;
      bus.ex_op1     <= '0;
      bus.ex_op2     <= '0;
    end else begin
      bus.ex_valid   <= bus.in_valid;
      bus.ex_pc      <= bus.in_pc;
      bus.ex_imm     <= bus.in_imm;
      bus.ex_rs1     <= bus.in_rs1;
      bus.ex_rs2     <= bus.in_rs2;
      bus.ex_rd      <= bus.in_rd;
      bus.ex_is_load <= bus.in_is_load;
      bus.ex_ctrl    <= ctrl_d;
      bus.ex_op1     <= op1_d;
      bus.ex_op2     <= op2_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.stall_cnt <= '0;
    else if (bus.stall_req && bus.stall_cnt != {STALL_CNT_W{1'b1}})
      bus.stall_cnt <= bus.stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases then randomized traffic against a reference model.
// A narrow stall counter makes saturation reachable in a short run.
module tb_id_ex_stage;
  localparam int CTRL_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if #(.CTRL_W(CTRL_W), .STALL_CNT_W(CNT_W)) bus ();
  id_ex_stage #(.CTRL_W(CTRL_W), .STALL_CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the EX-side register and stall count
  logic              m_valid, m_load, m_stall;
  logic [31:0]       m_pc, m_imm, m_op1, m_op2;
  logic [4:0]        m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_valid = 0; m_load = 0; m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
  endtask

  function automatic logic [31:0] exp_op(input logic [4:0] rs, input logic [31:0] rd_data);
    if (rs == 5'd0) return 32'd0;
`ifdef IDEX_WB_BYPASS_EN
    if (bus.wb_WE3 && bus.wb_A3 == rs) return bus.wb_WD3;
`endif
    return rd_data;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, "_valid"}, 32'(bus.ex_valid), 32'(m_valid));
    chk({tag, "_pc"},    bus.ex_pc, m_pc);
    chk({tag, "_imm"},   bus.ex_imm, m_imm);
    chk({tag, "_rs1"},   32'(bus.ex_rs1), 32'(m_rs1));
    chk({tag, "_rs2"},   32'(bus.ex_rs2), 32'(m_rs2));
    chk({tag, "_rd"},    32'(bus.ex_rd), 32'(m_rd));
    chk({tag, "_load"},  32'(bus.ex_is_load), 32'(m_load));
    chk({tag, "_ctrl"},  32'(bus.ex_ctrl), 32'(m_ctrl));
    chk({tag, "_op1"},   bus.ex_op1, m_op1);
    chk({tag, "_op2"},   bus.ex_op2, m_op2);
    chk({tag, "_cnt"},   32'(bus.stall_cnt), 32'(m_cnt));
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    logic hz;
    logic [31:0] o1, o2;
    #1;
    hz = bus.in_valid && m_valid && m_load && m_rd != 0 &&
         (m_rd == bus.in_rs1 || m_rd == bus.in_rs2);
    m_stall = hz && !bus.flush;
    chk({tag, "_A1"}, 32'(bus.A1), 32'(bus.in_rs1));
    chk({tag, "_A2"}, 32'(bus.A2), 32'(bus.in_rs2));
    chk({tag, "_stall_req"}, 32'(bus.stall_req), 32'(m_stall));
    o1 = exp_op(bus.in_rs1, bus.RD1);
    o2 = exp_op(bus.in_rs2, bus.RD2);
    @(posedge clk);
    if (m_stall && m_cnt < CNT_MAX) m_cnt++;
    if (bus.flush || hz) m_clear();
    else begin
      m_valid = bus.in_valid; m_pc = bus.in_pc; m_imm = bus.in_imm;
      m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2; m_rd = bus.in_rd;
      m_load = bus.in_is_load; m_ctrl = bus.in_ctrl; m_op1 = o1; m_op2 = o2;
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic ld);
    bus.in_valid = v; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_is_load = ld;
    bus.in_pc = $urandom; bus.in_imm = $urandom; bus.in_ctrl = CTRL_W'($urandom);
    bus.flush = 0; bus.wb_WE3 = 0; bus.wb_A3 = 0; bus.wb_WD3 = 0;
    bus.RD1 = $urandom; bus.RD2 = $urandom;
  endtask

  int cnt0;

  initial begin
    reset = 1'b1;
    set_instr(0, 0, 0, 0, 0);
    m_clear(); m_cnt = 0; m_stall = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // pass-through
    set_instr(1, 5'd3, 5'd20, 5'd4, 0);
    bus.RD1 = 32'hD; bus.RD2 = 32'h5;
    step("t2");
    chk("t2_op1_const", bus.ex_op1, 32'hD);
    chk("t2_op2_const", bus.ex_op2, 32'h5);

    // load-use on rs2
    set_instr(1, 5'd1, 5'd2, 5'd11, 1);
    step("t3_ld");
    set_instr(1, 5'd9, 5'd11, 5'd12, 0);
    step("t3_stall");
    chk("t3_bubble", 32'(bus.ex_valid), 32'd0);
    step("t3_retry");
    chk("t3_captured", 32'(bus.ex_valid), 32'd1);
    chk("t3_cnt", 32'(bus.stall_cnt), 32'd1);

    // writeback bypass
    set_instr(1, 5'd11, 5'd0, 5'd2, 0);
    bus.RD1 = 32'h0; bus.wb_A3 = 5'd11; bus.wb_WE3 = 1; bus.wb_WD3 = 32'hAA791D;
    step("t4");
`ifdef IDEX_WB_BYPASS_EN
    chk("t4_op1_const", bus.ex_op1, 32'hAA791D);
`else
    chk("t4_op1_const", bus.ex_op1, 32'h0);
`endif

    // x0 never bypassed
    set_instr(1, 5'd0, 5'd0, 5'd2, 0);
    bus.RD1 = 32'h1; bus.wb_A3 = 5'd0; bus.wb_WE3 = 1; bus.wb_WD3 = 32'hFFFF;
    step("t5");
    chk("t5_op1_const", bus.ex_op1, 32'h0);

    // flush and hazard together
    set_instr(1, 5'd1, 5'd1, 5'd7, 1);
    step("t6_ld");
    cnt0 = m_cnt;
    set_instr(1, 5'd7, 5'd3, 5'd8, 0);
    bus.flush = 1;
    step("t6_flush");
    chk("t6_cnt_held", 32'(bus.stall_cnt), 32'(cnt0));

    // randomized traffic; upstream holds the instruction while stalled
    for (int i = 0; i < 250; i++) begin
      if (!m_stall) begin
        bus.in_valid = ($urandom % 8) != 0;
        bus.in_rs1 = 5'($urandom % 4); bus.in_rs2 = 5'($urandom % 4);
        bus.in_rd = 5'($urandom % 4); bus.in_is_load = $urandom % 2;
        bus.in_pc = $urandom; bus.in_imm = $urandom; bus.in_ctrl = CTRL_W'($urandom);
      end
      bus.flush = ($urandom % 10) == 0;
      bus.RD1 = $urandom; bus.RD2 = $urandom;
      bus.wb_WE3 = $urandom % 2; bus.wb_A3 = 5'($urandom % 4); bus.wb_WD3 = $urandom;
      step("rnd");
    end

    // asynchronous reset mid-cycle with a valid instruction in EX
    set_instr(1, 5'd5, 5'd6, 5'd9, 1);
    step("t1_pre");
    #2 reset = 1'b1;
    #1;
    m_clear(); m_cnt = 0; m_stall = 0;
    check_regs("t1");
    @(negedge clk);
    reset = 1'b0;

    // force enough load-use stalls to saturate the counter
    for (int i = 0; i < 20; i++) begin
      set_instr(1, 5'd0, 5'd0, 5'd5, 1);
      step("sat_ld");
      set_instr(1, 5'd5, 5'd0, 5'd6, 0);
      step("sat_stall");
      step("sat_retry");
    end
    chk("sat_const", 32'(bus.stall_cnt), 32'(CNT_MAX));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
